// File: rtl/alu_exec_stage_pkg.sv
// rtl/alu_exec_stage_pkg.sv - ALU control codes, exception codes and helpers shared by the EX stage
package alu_exec_stage_pkg;

    localparam int CTRL_W = 5;
    localparam int EXC_W  = 2;

    // ALU control codes produced by the upstream ALU control decoder.
    // Codes 19..30 are unassigned and are treated like ALU_INVALID.
    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD     = 5'd0,
        ALU_ADDU    = 5'd1,
        ALU_SUB     = 5'd2,
        ALU_SUBU    = 5'd3,
        ALU_AND     = 5'd4,
        ALU_OR      = 5'd5,
        ALU_XOR     = 5'd6,
        ALU_NOR     = 5'd7,
        ALU_SLT     = 5'd8,
        ALU_SLTU    = 5'd9,
        ALU_SLL     = 5'd10,
        ALU_SRL     = 5'd11,
        ALU_SRA     = 5'd12,
        ALU_LUI     = 5'd13,
        ALU_LE      = 5'd14,
        ALU_GT      = 5'd15,
        ALU_GE      = 5'd16,
        ALU_JR      = 5'd17,
        ALU_JALR    = 5'd18,
        ALU_INVALID = 5'd31
    } alu_ctrl_e;

    // Exception codes, shared with the interrupt/CP0 logic.
    typedef enum logic [EXC_W-1:0] {
        EXC_NONE = 2'd0,
        EXC_OV   = 2'd1,
        EXC_INV  = 2'd2
    } exc_e;

    function automatic logic is_jump(input logic [CTRL_W-1:0] ctrl);
        return (ctrl == ALU_JR) || (ctrl == ALU_JALR);
    endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - input/output bundles of the EX stage with valid/ready handshakes
//  slave  : the EX stage (consumes in_*, drives in_ready and out_*)
//  master : the surrounding pipeline (drives in_*, out_ready)
interface alu_exec_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    import alu_exec_stage_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_aluctrl;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [4:0]        in_shamt;
    logic [REG_AW-1:0] in_rd;
    logic              in_wen;
    logic [DATA_W-1:0] in_pc;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic              out_jump;
    logic [REG_AW-1:0] out_rd;
    logic              out_wen;
    logic [EXC_W-1:0]  out_exc;
    logic [DATA_W-1:0] out_pc;

    modport slave (
        input  in_valid, in_aluctrl, in_a, in_b, in_shamt, in_rd, in_wen, in_pc,
        output in_ready,
        output out_valid, out_result, out_zero, out_jump, out_rd, out_wen, out_exc, out_pc,
        input  out_ready
    );

    modport master (
        output in_valid, in_aluctrl, in_a, in_b, in_shamt, in_rd, in_wen, in_pc,
        input  in_ready,
        input  out_valid, out_result, out_zero, out_jump, out_rd, out_wen, out_exc, out_pc,
        output out_ready
    );

endinterface

// File: rtl/alu_exec_stage_core.sv
// rtl/alu_exec_stage_core.sv - combinational ALU: (ctrl, a, b, shamt) -> (result, overflow, invalid)
//  ctrl_i    : ALU control code
//  a_i, b_i  : operands
//  shamt_i   : shift amount
//  result_o  : computed result (zero for invalid codes)
//  ovf_o     : signed overflow of ALU_ADD / ALU_SUB
//  invalid_o : control code is ALU_INVALID or unassigned
module alu_exec_stage_core
    import alu_exec_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [4:0]        shamt_i,
    output logic [DATA_W-1:0] result_o,
    output logic              ovf_o,
    output logic              invalid_o
);
    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] b_neg;
    logic [DATA_W-1:0] diff;
    logic              a_is_zero;

    always_comb begin
        sum       = a_i + b_i;
        b_neg     = ~b_i + 1'b1;
        diff      = a_i + b_neg;
        a_is_zero = (a_i == '0);
        result_o  = '0;
        ovf_o     = 1'b0;
        invalid_o = 1'b0;
        case (ctrl_i)
            ALU_ADD: begin
                result_o = sum;
                ovf_o    = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
            end
            ALU_SUB: begin
                // Overflow rule applied to A + (-B); for B = most-negative, -B wraps to itself.
                result_o = diff;
                ovf_o    = (a_i[MSB] == b_neg[MSB]) && (diff[MSB] != a_i[MSB]);
            end
            ALU_ADDU: result_o = sum;
            ALU_SUBU: result_o = diff;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_SLT:  result_o = DATA_W'($signed(a_i) < $signed(b_i));
            ALU_SLTU: result_o = DATA_W'(a_i < b_i);
            ALU_SLL:  result_o = b_i << shamt_i;
            ALU_SRL:  result_o = b_i >> shamt_i;
            ALU_SRA:  result_o = $unsigned($signed(b_i) >>> shamt_i);
            ALU_LUI:  result_o = {b_i[15:0], {(DATA_W-16){1'b0}}};
            ALU_LE:   result_o = DATA_W'(a_i[MSB] | a_is_zero);
            ALU_GT:   result_o = DATA_W'(!a_i[MSB] && !a_is_zero);
            ALU_GE:   result_o = DATA_W'(!a_i[MSB]);
            ALU_JR,
            ALU_JALR: result_o = a_i;
            default:  invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - EX stage: ALU core plus one-entry output register with valid/ready and flush
//  clk   : clock, all state on rising edge
//  rst   : synchronous reset, active-high (wins over flush)
//  flush : drops the held output and any bundle accepted this cycle
//  bus   : slave side of the in/out handshake bundles
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    alu_exec_stage_if.slave     bus
);
    logic [DATA_W-1:0] result_d;
    logic              ovf_d;
    logic              invalid_d;
    exc_e              exc_d;
    logic              accept;

    logic              valid_q;
    logic [DATA_W-1:0] result_q;
    logic              jump_q;
    logic [REG_AW-1:0] rd_q;
    logic              wen_q;
    exc_e              exc_q;
    logic [DATA_W-1:0] pc_q;

    alu_exec_stage_core #(.DATA_W(DATA_W)) u_core (
        .ctrl_i    (bus.in_aluctrl),
        .a_i       (bus.in_a),
        .b_i       (bus.in_b),
        .shamt_i   (bus.in_shamt),
        .result_o  (result_d),
        .ovf_o     (ovf_d),
        .invalid_o (invalid_d)
    );

    // Flush deliberately does not gate in_ready; a bundle accepted under flush is simply dropped.
    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign exc_d        = invalid_d ? EXC_INV : (ovf_d ? EXC_OV : EXC_NONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            jump_q   <= 1'b0;
            rd_q     <= '0;
            wen_q    <= 1'b0;
            exc_q    <= EXC_NONE;
            pc_q     <= '0;
        end else if (flush) begin
            valid_q  <= 1'b0;
            wen_q    <= 1'b0;
            exc_q    <= EXC_NONE;
        end else if (accept) begin
            valid_q  <= 1'b1;
            result_q <= result_d;
            jump_q   <= is_jump(bus.in_aluctrl);
            rd_q     <= bus.in_rd;
            wen_q    <= bus.in_wen && (exc_d == EXC_NONE);
            exc_q    <= exc_d;
            pc_q     <= bus.in_pc;
        end else if (bus.out_ready) begin
            valid_q  <= 1'b0;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_result = result_q;
    assign bus.out_zero   = (result_q == '0);
    assign bus.out_jump   = jump_q;
    assign bus.out_rd     = rd_q;
    assign bus.out_wen    = wen_q;
    assign bus.out_exc    = exc_q;
    assign bus.out_pc     = pc_q;

endmodule
